seg_scan_mux: RTL and testbench

//  Downstream stage of the traffic-light display: takes the eight 7-segment digit patterns (N/E/S/W msb/lsb)
//  and time-multiplexes them onto one shared segment bus with one-hot digit enables.

---
 rtl/seg_scan_mux_pkg.sv | 13 +
 rtl/seg_scan_mux_scan_slot_counter.sv | 35 +++
 rtl/seg_scan_mux.sv | 115 +++++++++++
 tb/tb_seg_scan_mux.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_mux_pkg.sv
// Shared constants and FSM state type for the segment scan multiplexer.
package seg_scan_mux_pkg;

  localparam logic [6:0] SEG_ZERO = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_t;

endpackage

// File: rtl/seg_scan_mux_scan_slot_counter.sv
// Slot timing: cycle-within-slot counter, digit index, and slot/frame end strobes.
module scan_slot_counter #(
  parameter int unsigned DIGIT_CYC = 4,
  parameter int unsigned CNT_W     = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             run,
  output logic [CNT_W-1:0] cnt,
  output logic [2:0]       digit_idx,
  output logic             slot_end,
  output logic             frame_end
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGIT_CYC - 1);

  assign slot_end  = run && (cnt == CNT_LAST);
  assign frame_end = slot_end && (digit_idx == 3'd7);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt       <= '0;
      digit_idx <= '0;
    end else if (run) begin
      if (slot_end) begin
        cnt       <= '0;
        digit_idx <= digit_idx + 3'd1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexes eight frame-snapshotted 7-segment patterns onto one bus with blanking gaps.
module seg_scan_mux
  import seg_scan_mux_pkg::*;
#(
  parameter int unsigned DIGIT_CYC      = 4,
  parameter int unsigned BLANK_CYC      = 1,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       blank_lz,
  input  logic [6:0] n_msb,
  input  logic [6:0] n_lsb,
  input  logic [6:0] e_msb,
  input  logic [6:0] e_lsb,
  input  logic [6:0] s_msb,
  input  logic [6:0] s_lsb,
  input  logic [6:0] w_msb,
  input  logic [6:0] w_lsb,
  output logic [6:0] seg,
  output logic [7:0] an,
  output logic [2:0] digit_idx,
  output logic       frame_done
);

  localparam int unsigned CNT_W = (DIGIT_CYC > 1) ? $clog2(DIGIT_CYC) : 1;
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYC == 0) ? 0 : BLANK_CYC - 1);
  localparam scan_state_t SLOT_FIRST = (BLANK_CYC == 0) ? SHOW : BLANK;

  scan_state_t      state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic             slot_end, frame_end;
  logic [6:0]       snap [8];
  logic             lz_q;
  logic             load;
  logic [6:0]       cur;
  logic             suppress;
  logic [7:0]       an_act;
  logic [6:0]       seg_act;

  scan_slot_counter #(
    .DIGIT_CYC (DIGIT_CYC),
    .CNT_W     (CNT_W)
  ) u_counter (
    .clk       (clk),
    .reset     (reset),
    .clear     (!enable || (state == IDLE)),
    .run       (state != IDLE),
    .cnt       (cnt),
    .digit_idx (digit_idx),
    .slot_end  (slot_end),
    .frame_end (frame_end)
  );

  assign frame_done = frame_end;
  assign load       = enable && ((state == IDLE) || frame_end);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // blank_lz is registered so the display outputs depend on flops only.
  always_ff @(posedge clk) begin
    if (reset) begin
      lz_q <= 1'b0;
      for (int unsigned i = 0; i < 8; i++) snap[i] <= '0;
    end else begin
      lz_q <= blank_lz;
      if (load) begin
        snap[0] <= n_msb;
        snap[1] <= n_lsb;
        snap[2] <= e_msb;
        snap[3] <= e_lsb;
        snap[4] <= s_msb;
        snap[5] <= s_lsb;
        snap[6] <= w_msb;
        snap[7] <= w_lsb;
      end
    end
  end

  always_comb begin
    state_nx = state;
    if (!enable) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE:    state_nx = SLOT_FIRST;
        BLANK:   if (cnt == BLANK_LAST) state_nx = SHOW;
        SHOW:    if (slot_end) state_nx = SLOT_FIRST;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    cur      = snap[digit_idx];
    suppress = lz_q && !digit_idx[0] && (cur == SEG_ZERO);
    an_act   = '0;
    seg_act  = SEG_OFF;
    if ((state == SHOW) && !suppress) begin
      an_act[digit_idx] = 1'b1;
      seg_act           = cur;
    end
    an  = AN_ACTIVE_LOW  ? ~an_act  : an_act;
    seg = SEG_ACTIVE_LOW ? ~seg_act : seg_act;
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Self-checking bench for seg_scan_mux against a frame-timeline reference model.
module tb_seg_scan_mux;

  logic       clk = 1'b0;
  logic       reset, enable, blank_lz;
  logic [6:0] n_msb, n_lsb, e_msb, e_lsb, s_msb, s_lsb, w_msb, w_lsb;
  logic [6:0] seg;
  logic [7:0] an;
  logic [2:0] digit_idx;
  logic       frame_done;

  int checks   = 0;
  int failures = 0;

  bit          m_active = 1'b0;
  int unsigned m_t      = 0;
  logic [6:0]  m_snap [8];

  always #5 clk = ~clk;

  seg_scan_mux #(
    .DIGIT_CYC      (4),
    .BLANK_CYC      (1),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .blank_lz   (blank_lz),
    .n_msb      (n_msb),
    .n_lsb      (n_lsb),
    .e_msb      (e_msb),
    .e_lsb      (e_lsb),
    .s_msb      (s_msb),
    .s_lsb      (s_lsb),
    .w_msb      (w_msb),
    .w_lsb      (w_lsb),
    .seg        (seg),
    .an         (an),
    .digit_idx  (digit_idx),
    .frame_done (frame_done)
  );

  function automatic logic [6:0] pat(int unsigned i);
    case (i)
      0: return n_msb;
      1: return n_lsb;
      2: return e_msb;
      3: return e_lsb;
      4: return s_msb;
      5: return s_lsb;
      6: return w_msb;
      default: return w_lsb;
    endcase
  endfunction

  task automatic set_pat(int unsigned i, logic [6:0] v);
    case (i)
      0: n_msb = v;
      1: n_lsb = v;
      2: e_msb = v;
      3: e_lsb = v;
      4: s_msb = v;
      5: s_lsb = v;
      6: w_msb = v;
      default: w_lsb = v;
    endcase
  endtask

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: a frame is 32 cycles, slot = t/4, first cycle of each slot dark.
  task automatic step();
    int unsigned slot, ph;
    logic [7:0]  e_an;
    logic [6:0]  e_seg;
    logic [2:0]  e_idx;
    logic        e_fd;
    bit          seg_chk;
    @(posedge clk);
    if (reset || !enable) begin
      m_active = 1'b0;
    end else if (!m_active) begin
      m_active = 1'b1;
      m_t = 0;
      for (int unsigned i = 0; i < 8; i++) m_snap[i] = pat(i);
    end else begin
      m_t = (m_t + 1) % 32;
      if (m_t == 0) for (int unsigned i = 0; i < 8; i++) m_snap[i] = pat(i);
    end
    #1;
    e_an = 8'hFF; e_seg = 7'h7F; e_idx = 3'd0; e_fd = 1'b0; seg_chk = 1'b1;
    if (m_active) begin
      slot  = m_t / 4;
      ph    = m_t % 4;
      e_idx = 3'(slot);
      e_fd  = (m_t == 31);
      if (ph >= 1) begin
        if (blank_lz && (slot % 2 == 0) && (m_snap[slot] == 7'h3F)) begin
          seg_chk = 1'b0;
        end else begin
          e_an  = ~(8'd1 << slot);
          e_seg = ~m_snap[slot];
        end
      end
    end
    chk("an", an, e_an);
    if (seg_chk) chk("seg", {1'b0, seg}, {1'b0, e_seg});
    chk("digit_idx", {5'd0, digit_idx}, {5'd0, e_idx});
    chk("frame_done", {7'd0, frame_done}, {7'd0, e_fd});
  endtask

  task automatic rnd_pats();
    for (int unsigned i = 0; i < 8; i++)
      set_pat(i, ($urandom_range(0, 3) == 0) ? 7'h3F : 7'($urandom_range(0, 127)));
  endtask

  // blank_lz only moves while dark so its one-cycle pipeline never lands in a lit slot.
  task automatic run(int unsigned n, bit mutate, bit drop_en);
    for (int unsigned k = 0; k < n; k++) begin
      if (mutate && $urandom_range(0, 3) == 0)
        set_pat($urandom_range(0, 7), 7'($urandom_range(0, 127)));
      if (mutate && (!m_active || m_t % 4 == 0) && $urandom_range(0, 7) == 0)
        blank_lz = 1'($urandom_range(0, 1));
      enable = !(drop_en && $urandom_range(0, 59) == 0);
      step();
    end
    enable = 1'b1;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; blank_lz = 1'b0;
    n_msb = 7'h06; n_lsb = 7'h5B; e_msb = 7'h4F; e_lsb = 7'h66;
    s_msb = 7'h6D; s_lsb = 7'h7D; w_msb = 7'h07; w_lsb = 7'h7F;
    for (int unsigned i = 0; i < 8; i++) m_snap[i] = '0;

    step();
    step();
    reset = 1'b0;

    run(66, 1'b0, 1'b0);

    for (int k = 0; k < 64 && !(m_active && m_t / 4 == 1); k++) step();
    chk("reach_slot1", {7'd0, m_active && (m_t / 4 == 1)}, 8'd1);
    e_lsb = 7'h6D;
    run(70, 1'b0, 1'b0);

    for (int k = 0; k < 64 && !(m_active && m_t == 0); k++) step();
    chk("reach_frame0", {7'd0, m_active && (m_t == 0)}, 8'd1);
    blank_lz = 1'b1; s_msb = 7'h3F; s_lsb = 7'h3F; n_msb = 7'h3F;
    run(70, 1'b0, 1'b0);

    for (int k = 0; k < 64 && !(m_active && m_t == 22); k++) step();
    chk("reach_slot5_show", {7'd0, m_active && (m_t == 22)}, 8'd1);
    enable = 1'b0;
    step();
    chk("dis_an", an, 8'hFF);
    chk("dis_seg", {1'b0, seg}, 8'h7F);
    enable = 1'b1;
    step();
    chk("idle_an", an, 8'hFF);
    step();
    chk("restart_idx", {5'd0, digit_idx}, 8'd0);
    run(40, 1'b0, 1'b0);

    for (int k = 0; k < 64 && !(m_active && m_t / 4 == 6); k++) step();
    chk("reach_slot6", {7'd0, m_active && (m_t / 4 == 6)}, 8'd1);
    reset = 1'b1;
    step();
    chk("rst_an", an, 8'hFF);
    chk("rst_seg", {1'b0, seg}, 8'h7F);
    reset = 1'b0;
    rnd_pats();
    run(40, 1'b0, 1'b0);

    for (int unsigned f = 0; f < 8; f++) begin
      rnd_pats();
      run(32, 1'b1, f > 3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
